// File: rtl/wram_pkg.sv
// Shared types and constants for the banked work RAM.
// Grant and clear-state encodings plus the width helper.
package wram_pkg;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_VID,
      GNT_CPU,
      GNT_CLR
   } gnt_e;

   typedef enum logic {
      CLR_IDLE,
      CLR_RUN
   } clr_e;

   localparam string WRAM_INIT_DEF = "empty2k.ram";

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/banked_work_ram_if.sv
// CPU bus, video scan and clear-control signals of banked_work_ram.
// master drives requests, slave is the RAM block.
interface banked_work_ram_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int LANES  = 2,
   parameter int VID_W  = 6
);
   logic                    cpu_req;
   logic                    cpu_we;
   logic [ADDR_W-1:0]       cpu_addr;
   logic [DATA_W-1:0]       cpu_wdata;
   logic                    cpu_ready;
   logic [DATA_W-1:0]       cpu_rdata;
   logic                    cpu_rvalid;
   logic                    vid_req;
   logic [VID_W-1:0]        vid_idx;
   logic                    buf_sel;
   logic [LANES*DATA_W-1:0] vid_rdata;
   logic                    vid_rvalid;
   logic                    vid_drop;
   logic                    clear_start;
   logic                    clear_busy;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output vid_req, vid_idx, buf_sel, clear_start,
      input  cpu_ready, cpu_rdata, cpu_rvalid,
      input  vid_rdata, vid_rvalid, vid_drop, clear_busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  vid_req, vid_idx, buf_sel, clear_start,
      output cpu_ready, cpu_rdata, cpu_rvalid,
      output vid_rdata, vid_rvalid, vid_drop, clear_busy
   );
endinterface

// File: rtl/wram_lane.sv
// One byte lane of the work RAM: synchronous write, registered
// read-before-write output.
module wram_lane
   import wram_pkg::*;
#(
   parameter int    DATA_W    = 8,
   parameter int    AW        = 11,
   parameter string INIT_FILE = WRAM_INIT_DEF
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   logic [DATA_W-1:0] mem_q [2**AW];
   logic [DATA_W-1:0] dout_q;

   // The image named by INIT_FILE is bound by the memory macro flow.
   if (INIT_FILE == "") begin : g_no_image
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= din;
      dout_q <= mem_q[addr];
   end

   assign dout = dout_q;
endmodule

// File: rtl/banked_work_ram.sv
// Byte-interleaved work RAM shared by CPU and video line scan.
// Define WRAM_AUTOCLEAR_EN to build the back-buffer clear engine.
module banked_work_ram
   import wram_pkg::*;
#(
   parameter int              ADDR_W      = 12,
   parameter int              DATA_W      = 8,
   parameter int              LANES       = 2,
   parameter int              VID_W       = 6,
   parameter logic [ADDR_W-1:0] VID_BASE  = '1,
   parameter int              CPU_MAXWAIT = 4,
   parameter string           INIT_FILE   = WRAM_INIT_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   banked_work_ram_if.slave bus
);
   localparam int LB   = clog2(LANES);
   localparam int AW   = ADDR_W - LB;
   localparam int VB_W = AW - 1 - VID_W;
   localparam int WW   = clog2(CPU_MAXWAIT + 1);
   localparam logic [WW-1:0] MAXW = WW'(CPU_MAXWAIT);

   gnt_e                    gnt;
   logic                    force_cpu;
   logic [WW-1:0]           wait_q, wait_d;
   logic [LB-1:0]           lane_sel;
   logic [LB-1:0]           cpu_lane_q, cpu_lane_d;
   logic [AW-1:0]           cpu_wa, vid_wa, clr_wa, ram_a;
   logic [DATA_W-1:0]       ram_din;
   logic [LANES-1:0]        ram_we;
   logic [DATA_W-1:0]       ram_dout [LANES];
   logic [LANES*DATA_W-1:0] vid_word;
   logic                    cpu_rvalid_q, cpu_rvalid_d;
   logic                    vid_rvalid_q, vid_rvalid_d;
   logic [DATA_W-1:0]       cpu_hold_q, cpu_hold_d;
   logic [LANES*DATA_W-1:0] vid_hold_q, vid_hold_d;
   logic                    clr_busy;

   assign lane_sel = bus.cpu_addr[LB-1:0];
   assign cpu_wa   = bus.cpu_addr[ADDR_W-1:LB];
   assign vid_wa   = {VID_BASE[VB_W-1:0], bus.buf_sel, bus.vid_idx};

`ifdef WRAM_AUTOCLEAR_EN
   clr_e             clr_st_q, clr_st_d;
   logic             clr_tgt_q, clr_tgt_d;
   logic [VID_W-1:0] clr_cnt_q, clr_cnt_d;

   // Target buffer is latched at start so buf_sel flips cannot retarget.
   always_comb begin
      clr_st_d  = clr_st_q;
      clr_tgt_d = clr_tgt_q;
      clr_cnt_d = clr_cnt_q;
      unique case (clr_st_q)
         CLR_IDLE: if (bus.clear_start) begin
            clr_st_d  = CLR_RUN;
            clr_tgt_d = ~bus.buf_sel;
            clr_cnt_d = '0;
         end
         CLR_RUN: if (gnt == GNT_CLR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) clr_st_d = CLR_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clr_st_q  <= CLR_IDLE;
         clr_tgt_q <= 1'b0;
         clr_cnt_q <= '0;
      end else begin
         clr_st_q  <= clr_st_d;
         clr_tgt_q <= clr_tgt_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   assign clr_busy = (clr_st_q == CLR_RUN);
   assign clr_wa   = {VID_BASE[VB_W-1:0], clr_tgt_q, clr_cnt_q};
`else
   logic unused_clear_start;
   assign unused_clear_start = bus.clear_start;
   assign clr_busy = 1'b0;
   assign clr_wa   = '0;
`endif

   always_comb begin
      force_cpu = reset_n && bus.cpu_req && (wait_q == MAXW);
      gnt = GNT_NONE;
      priority case (1'b1)
         !reset_n:    gnt = GNT_NONE;
         force_cpu:   gnt = GNT_CPU;
         bus.vid_req: gnt = GNT_VID;
         bus.cpu_req: gnt = GNT_CPU;
         clr_busy:    gnt = GNT_CLR;
         default:     gnt = GNT_NONE;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if (!bus.cpu_req || gnt == GNT_CPU) wait_d = '0;
      else if (wait_q != MAXW) wait_d = wait_q + 1'b1;
   end

   always_comb begin
      ram_a   = cpu_wa;
      ram_din = bus.cpu_wdata;
      ram_we  = '0;
      unique case (gnt)
         GNT_VID: ram_a = vid_wa;
         GNT_CPU: ram_we[lane_sel] = bus.cpu_we;
         GNT_CLR: begin
            ram_a   = clr_wa;
            ram_din = '0;
            ram_we  = '1;
         end
         default: ;
      endcase
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      wram_lane #(
         .DATA_W(DATA_W), .AW(AW), .INIT_FILE(INIT_FILE)
      ) u_lane (
         .clk(clk), .we(ram_we[l]), .addr(ram_a),
         .din(ram_din), .dout(ram_dout[l])
      );
      assign vid_word[l*DATA_W +: DATA_W] = ram_dout[l];
   end

   // Lane outputs move on every access; holds keep rdata stable.
   always_comb begin
      cpu_rvalid_d = (gnt == GNT_CPU) && !bus.cpu_we;
      vid_rvalid_d = (gnt == GNT_VID);
      cpu_lane_d   = cpu_rvalid_d ? lane_sel : cpu_lane_q;
      cpu_hold_d   = bus.cpu_rdata;
      vid_hold_d   = bus.vid_rdata;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wait_q       <= '0;
         cpu_lane_q   <= '0;
         cpu_rvalid_q <= 1'b0;
         vid_rvalid_q <= 1'b0;
         cpu_hold_q   <= '0;
         vid_hold_q   <= '0;
      end else begin
         wait_q       <= wait_d;
         cpu_lane_q   <= cpu_lane_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vid_rvalid_q <= vid_rvalid_d;
         cpu_hold_q   <= cpu_hold_d;
         vid_hold_q   <= vid_hold_d;
      end
   end

   assign bus.cpu_ready  = (gnt == GNT_CPU);
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_rdata  = cpu_rvalid_q ? ram_dout[cpu_lane_q] : cpu_hold_q;
   assign bus.vid_rvalid = vid_rvalid_q;
   assign bus.vid_rdata  = vid_rvalid_q ? vid_word : vid_hold_q;
   assign bus.vid_drop   = force_cpu && bus.vid_req;
   assign bus.clear_busy = clr_busy;
endmodule

// File: doc/banked_work_ram.md
Name: banked_work_ram

Overview:
- Parametrised working-RAM block: LANES byte-interleaved synchronous RAM banks shared between the CPU port and a video scan port.
- The video scan port reads one double-buffered object line per request.
- A cycle arbiter gives video priority, with a CPU starvation guard.
- Successor to the fixed 2-lane, phase-muxed work RAM; drops in where the CPU bus meets the motion-object line buffer.

Parameters:
- ADDR_W, 12, CPU byte address width.
- DATA_W, 8, lane data width.
- LANES, 2, interleaved lanes, power of 2; lane select = cpu_addr[LB-1:0], where LB = log2(LANES).
- VID_W, 6, video index width; requires VID_W+1 <= ADDR_W-LB.
- VID_BASE, all ones, upper word-address bits of the video region.
- CPU_MAXWAIT, 4, consecutive denied CPU cycles before a forced CPU grant.
- INIT_FILE, "empty2k.ram", lane init image.

Ports:
- clk in 1: system clock, all logic on rising edge.
- reset_n in 1: synchronous active-low reset.
- cpu_req in 1: CPU access request.
- cpu_we in 1: 1 = write.
- cpu_addr in ADDR_W: byte address.
- cpu_wdata in DATA_W: write data.
- cpu_ready out 1: one-cycle pulse, access granted this cycle.
- cpu_rdata out DATA_W: read data.
- cpu_rvalid out 1: read data valid pulse.
- vid_req in 1: video line read request.
- vid_idx in VID_W: line slot index.
- buf_sel in 1: front buffer select.
- vid_rdata out LANES*DATA_W: all lanes, lane 0 in LSBs.
- vid_rvalid out 1: video data valid pulse.
- vid_drop out 1: pulse, video request lost to the starvation guard.
- clear_start in 1: start back-buffer clear.
- clear_busy out 1: clear in progress.

Behaviour:
- Reset (reset_n=0 at edge): all outputs 0, starvation counter 0, clear FSM IDLE. RAM contents are retained, not cleared.
- Video word address: {VID_BASE, buf_sel, vid_idx}. All lanes are read in parallel.
- CPU word address: cpu_addr[ADDR_W-1:LB]. Only the selected lane is written; the read returns the selected lane.
- Grant priority each cycle:
  1. Forced CPU, when wait count reaches CPU_MAXWAIT and cpu_req=1.
  2. Video.
  3. CPU.
  4. Clear.
- Exactly one grant per cycle.
- Latency: RAM read is registered. cpu_rvalid/vid_rvalid assert exactly 1 cycle after grant; rdata is held until the next valid.
- cpu_ready asserts in the grant cycle. Writes commit at that edge and never raise cpu_rvalid.
- The CPU holds cpu_we/addr/wdata stable while cpu_req=1 and cpu_ready=0. Dropping cpu_req before grant cancels the access with no side effect.
- Wait counter:
  - Increments on cycles with cpu_req=1 and no CPU grant; saturates at CPU_MAXWAIT.
  - Clears on CPU grant or cpu_req=0.
- Forced grant with vid_req=1: vid_drop pulses in that cycle, and no vid_rvalid follows for that request.
- Simultaneous write/read same address across ports: the write wins. The video read returns old data (read-before-write).
- Clear FSM (WRAM_AUTOCLEAR_EN only): IDLE -> CLEAR -> IDLE.
  - On clear_start in IDLE, latch target = ~buf_sel, counter = 0.
  - In CLEAR, each clear-granted cycle writes 0 to all lanes at {VID_BASE, target, counter}, then counter++.
  - After word 2^VID_W-1 is written -> IDLE.
  - clear_start while busy is ignored.
  - buf_sel changes during clear do not retarget.
  - clear_busy = (state==CLEAR).
  - reset_n low mid-clear aborts; the region is left partially cleared.

Optional Feature:
- Macro: WRAM_AUTOCLEAR_EN.
- Defined: clear FSM as above.
- Undefined: no FSM; clear_start ignored, clear_busy tied 0; arbiter has 3 sources only. Ports remain.

Decomposition:
- Package wram_pkg:
  - Grant enum: GNT_NONE, GNT_VID, GNT_CPU, GNT_CLR.
  - Clear state enum: CLR_IDLE, CLR_RUN.
  - Function clog2 for LB.
  - Default INIT_FILE constant.
- Sub-module wram_lane: single DATA_W x 2^(ADDR_W-LB) sync RAM with we, addr, din, dout and an INIT_FILE parameter. Instantiated LANES times via generate.

Test Plan:
- CPU write 0x5A to byte 0x003, then read 0x003, idle video -> cpu_ready in each grant cycle; cpu_rvalid 1 cycle after the read grant with 0x5A; lane 1 word 1 written, lane 0 unchanged.
- Video reads slot 5, buf_sel=1, after CPU writes 0x11/0x22 to bytes {VID_BASE,1,5,0}/{VID_BASE,1,5,1} -> vid_rvalid next cycle, vid_rdata=0x2211.
- vid_req held high 10 cycles with cpu_req=1 (read), CPU_MAXWAIT=4 -> CPU granted in the 5th cycle; vid_drop pulses that cycle; no vid_rvalid the next cycle; counter resets.
- Same-cycle CPU write 0xFF and video read of the same word holding 0x00 -> video gets 0x00; a subsequent video read gets 0xFF in that lane.
- WRAM_AUTOCLEAR_EN, buf_sel=0, clear_start with no other traffic -> clear_busy high for exactly 64 cycles. All buffer-1 words are 0; buffer-0 contents unchanged. A second clear_start while busy is ignored.
- reset_n low for 1 cycle mid-clear and mid-CPU-wait -> all outputs 0 next cycle, clear_busy 0, wait counter 0; RAM data written before reset is readable afterwards.
